// File: rtl/load_hazard_ctrl_pkg.sv
// Shared opcode constants, hazard action encoding and source-usage decode
// for the MIPS load hazard controller.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2,
    ST_FLUSH      = 2'd3
  } hazard_state_t;

  typedef struct packed {
    logic use_rs;
    logic use_rt;
    logic is_load;
    logic is_jump;
  } src_use_t;

  function automatic src_use_t decode_src(input logic [5:0] op);
    src_use_t u;
    u = '0;
    if (op == OP_RTYPE || op == OP_SW || op == OP_BEQ || op == OP_BNE) begin
      u.use_rs = 1'b1;
      u.use_rt = 1'b1;
    end else if (op == OP_LW) begin
      u.use_rs  = 1'b1;
      u.is_load = 1'b1;
    end else if (op[5:3] == 3'b001) begin
      u.use_rs = 1'b1;
    end else if (op == OP_J || op == OP_JAL) begin
      u.is_jump = 1'b1;
    end
    return u;
  endfunction

endpackage

// File: rtl/load_hazard_ctrl_if.sv
// Signal bundle between the ID-stage pipeline logic (master) and the hazard
// controller (slave).
// Protocol: no handshake; id_valid qualifies the ID fields each cycle, and every
// control output is a same-cycle combinational decision that the pipeline obeys.
interface load_hazard_ctrl_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             ex_branch_taken;
  logic             dmem_busy;
  logic             stall_clr;
  logic             pc_write;
  logic             ifid_write;
  logic             ifid_flush;
  logic             ctrl_sel;
  logic             pipe_hold;
  logic [1:0]       hazard_state;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, ex_branch_taken, dmem_busy, stall_clr,
    input  pc_write, ifid_write, ifid_flush, ctrl_sel, pipe_hold, hazard_state, stall_cnt
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, ex_branch_taken, dmem_busy, stall_clr,
    output pc_write, ifid_write, ifid_flush, ctrl_sel, pipe_hold, hazard_state, stall_cnt
  );
endinterface

// File: rtl/load_hazard_ctrl_scoreboard.sv
// Shift register of in-flight load destinations; entry 0 is the youngest.
// Flags a match against either enabled source register (register 0 ignored).
module load_scoreboard #(
  parameter int REG_W = 5,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze_i,
  input  logic             push_valid_i,
  input  logic [REG_W-1:0] push_reg_i,
  input  logic [REG_W-1:0] rs_i,
  input  logic             rs_en_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             rt_en_i,
  output logic             match_o
);

  logic [DEPTH-1:0] vld_q;
  logic [REG_W-1:0] reg_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) reg_q[i] <= '0;
    end else if (!freeze_i) begin
      vld_q[0] <= push_valid_i;
      reg_q[0] <= push_reg_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1];
        reg_q[i] <= reg_q[i-1];
      end
    end
  end

  always_comb begin
    match_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && reg_q[i] != '0 &&
          ((rs_en_i && reg_q[i] == rs_i) || (rt_en_i && reg_q[i] == rt_i)))
        match_o = 1'b1;
    end
  end

endmodule

// File: rtl/load_hazard_ctrl.sv
// ID-stage hazard controller: load-use stalls over a configurable load latency,
// branch/jump flushes, data-memory freeze and a saturating stall counter.
module load_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic              clk,
  input logic              rst,
  load_hazard_ctrl_if.slave bus
);

  src_use_t      dec;
  logic          hazard;
  logic          sb_freeze;
  logic          sb_push;
  hazard_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pc_write, ifid_write, ifid_flush, ctrl_sel, pipe_hold;

  always_comb begin
    dec = decode_src(bus.id_opcode);
    if (!bus.id_valid) dec = '0;
  end

  load_scoreboard #(.REG_W(REG_W), .DEPTH(LOAD_LAT)) u_sb (
    .clk          (clk),
    .rst          (rst),
    .freeze_i     (sb_freeze),
    .push_valid_i (sb_push),
    .push_reg_i   (bus.id_rt),
    .rs_i         (bus.id_rs),
    .rs_en_i      (dec.use_rs),
    .rt_i         (bus.id_rt),
    .rt_en_i      (dec.use_rt),
    .match_o      (hazard)
  );

  // Priority: memory freeze, taken branch, load-use, jump, normal flow.
  always_comb begin
    state_d    = ST_RUN;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    ctrl_sel   = 1'b1;
    pipe_hold  = 1'b0;
    sb_freeze  = 1'b0;
    sb_push    = 1'b0;
    if (!rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      ctrl_sel   = 1'b0;
    end else if (bus.dmem_busy) begin
      state_d    = ST_MEM_WAIT;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      pipe_hold  = 1'b1;
      sb_freeze  = 1'b1;
    end else if (bus.ex_branch_taken || (!hazard && dec.is_jump)) begin
      state_d    = ST_FLUSH;
      ifid_flush = 1'b1;
      ctrl_sel   = 1'b0;
    end else if (hazard) begin
      state_d    = ST_LOAD_STALL;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ctrl_sel   = 1'b0;
    end else begin
      sb_push = dec.is_load && (bus.id_rt != '0);
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.stall_clr) cnt_d = '0;
    else if (!pc_write && cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.pc_write     = pc_write;
  assign bus.ifid_write   = ifid_write;
  assign bus.ifid_flush   = ifid_flush;
  assign bus.ctrl_sel     = ctrl_sel;
  assign bus.pipe_hold    = pipe_hold;
  assign bus.hazard_state = state_q;
  assign bus.stall_cnt    = cnt_q;

endmodule
